// File: rtl/mb_i2p_fix_arranger_pkg.sv
// Shared token field layout, operator codes and FSM encoding for the infix-to-postfix arranger.
// Operators carry a 4-bit precedence class in code[7:4]; class 5 is reserved for parentheses.
package mb_i2p_fix_arranger_pkg;

  localparam int TYPE_BIT  = 32;
  localparam int CLASS_MSB = 7;
  localparam int CLASS_LSB = 4;
  localparam int ID_MSB    = 3;
  localparam int ID_LSB    = 0;
  localparam int CODE_W    = 12;

  localparam logic [3:0]        CLASS_PAREN = 4'h5;
  localparam logic [CODE_W-1:0] LPAREN      = 12'h150;
  localparam logic [CODE_W-1:0] RPAREN      = 12'h151;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_PROC,
    S_FLUSH,
    S_DONE
  } state_t;

  function automatic logic [3:0] tok_class(input logic [CODE_W-1:0] code);
    return code[CLASS_MSB:CLASS_LSB];
  endfunction

endpackage

// File: rtl/mb_i2p_fix_arranger_if.sv
// Token RAM read port, postfix RAM read port and control/status of the arranger.
// slave is the arranger side; master is the side that owns the token RAM and the evaluator.
interface mb_i2p_fix_arranger_if #(
  parameter int DWIDTH = 36,
  parameter int AWIDTH = 9
);
  logic              start;
  logic [DWIDTH-1:0] do_inf;
  logic [AWIDTH-1:0] top_addr_inf;
  logic              en_inf;
  logic [AWIDTH-1:0] addr_inf;
  logic [AWIDTH-1:0] addr_posf_b;
  logic [DWIDTH-1:0] do_posf_b;
  logic [AWIDTH-1:0] top_addr_posf;
  logic              finish;

  modport slave (
    input  start, do_inf, top_addr_inf, addr_posf_b,
    output en_inf, addr_inf, do_posf_b, top_addr_posf, finish
  );

  modport master (
    output start, do_inf, top_addr_inf, addr_posf_b,
    input  en_inf, addr_inf, do_posf_b, top_addr_posf, finish
  );
endinterface

// File: rtl/mb_i2p_fix_arranger_posf_ram.sv
// Postfix store: synchronous write on port A, registered read on port B (1-cycle latency).
// Always ready; contents survive reset, only the read register is cleared.
module i2p_posf_ram #(
  parameter int DWIDTH = 36,
  parameter int AWIDTH = 9
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_vld,
  input  logic [AWIDTH-1:0] wr_addr,
  input  logic [DWIDTH-1:0] wr_dat,
  input  logic [AWIDTH-1:0] rd_addr,
  output logic [DWIDTH-1:0] rd_dat
);

  logic [DWIDTH-1:0] mem [2**AWIDTH];

  always_ff @(posedge clk) begin
    if (wr_vld) mem[wr_addr] <= wr_dat;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_dat <= '0;
    else        rd_dat <= mem[rd_addr];
  end

endmodule

// File: rtl/mb_i2p_fix_arranger.sv
// Shunting-yard infix-to-postfix converter: one stack or output action per cycle, 2 cycles per token fetch.
// start is ignored while busy; stack overflow drops the token, the postfix write pointer saturates.
module mb_i2p_fix_arranger
  import mb_i2p_fix_arranger_pkg::*;
#(
  parameter int DWIDTH      = 36,
  parameter int AWIDTH      = 9,
  parameter int STACK_DEPTH = 16
) (
  input logic                   CLK_1MHz,
  input logic                   RSTN,
  mb_i2p_fix_arranger_if.slave  bus
);

  localparam int SPW  = $clog2(STACK_DEPTH + 1);
  localparam int IDXW = $clog2(STACK_DEPTH);

  state_t            state, state_nxt;
  logic [SPW-1:0]    sp;
  logic [AWIDTH-1:0] wp, wp_inc;
  logic [AWIDTH-1:0] addr_inf_q, top_addr_posf_q;
  logic              en_inf_q;
  logic [DWIDTH-1:0] stack [STACK_DEPTH];
  logic [DWIDTH-1:0] top_tok, pwr_dat;
  logic [CODE_W-1:0] tok_code, top_code;
  logic              tok_is_op, stk_empty, stk_full, last_tok;
  logic              kick, push, pop, pwr, tok_done;

  assign tok_code  = bus.do_inf[CODE_W-1:0];
  assign tok_is_op = bus.do_inf[TYPE_BIT];
  assign stk_empty = (sp == '0);
  assign stk_full  = (sp == SPW'(STACK_DEPTH));
  assign top_tok   = stack[IDXW'(sp - 1'b1)];
  assign top_code  = top_tok[CODE_W-1:0];
  assign wp_inc    = (wp == '1) ? wp : wp + 1'b1;
  assign last_tok  = (addr_inf_q == bus.top_addr_inf);

  assign bus.en_inf        = en_inf_q;
  assign bus.addr_inf      = addr_inf_q;
  assign bus.top_addr_posf = top_addr_posf_q;
  assign bus.finish        = (state == S_DONE);

  always_ff @(posedge CLK_1MHz or negedge RSTN) begin
    if (!RSTN) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    kick      = 1'b0;
    push      = 1'b0;
    pop       = 1'b0;
    pwr       = 1'b0;
    pwr_dat   = bus.do_inf;
    tok_done  = 1'b0;
    case (state)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          kick      = 1'b1;
          state_nxt = (bus.top_addr_inf == '0) ? S_DONE : S_WAIT;
        end
      end
      S_WAIT: state_nxt = S_PROC;
      S_PROC: begin
        if (!tok_is_op) begin
          pwr      = 1'b1;
          tok_done = 1'b1;
        end else if (tok_code == LPAREN) begin
          push     = 1'b1;
          tok_done = 1'b1;
        end else if (tok_code == RPAREN) begin
          // Drain down to the matching '(' and drop both; a stray ')' is just dropped.
          if (stk_empty) begin
            tok_done = 1'b1;
          end else if (top_code == LPAREN) begin
            pop      = 1'b1;
            tok_done = 1'b1;
          end else begin
            pop     = 1'b1;
            pwr     = 1'b1;
            pwr_dat = top_tok;
          end
        end else if (!stk_empty && top_code != LPAREN &&
                     tok_class(top_code) >= tok_class(tok_code)) begin
          pop     = 1'b1;
          pwr     = 1'b1;
          pwr_dat = top_tok;
        end else begin
          push     = 1'b1;
          tok_done = 1'b1;
        end
        if (tok_done) state_nxt = last_tok ? S_FLUSH : S_WAIT;
      end
      S_FLUSH: begin
        if (stk_empty) begin
          state_nxt = S_DONE;
        end else begin
          pop     = 1'b1;
          pwr     = (top_code != LPAREN);
          pwr_dat = top_tok;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK_1MHz or negedge RSTN) begin
    if (!RSTN) begin
      addr_inf_q      <= '0;
      en_inf_q        <= 1'b0;
      wp              <= '0;
      sp              <= '0;
      top_addr_posf_q <= '0;
    end else if (kick) begin
      addr_inf_q <= AWIDTH'(1);
      en_inf_q   <= (bus.top_addr_inf != '0);
      wp         <= '0;
      sp         <= '0;
      if (bus.top_addr_inf == '0) top_addr_posf_q <= '0;
    end else begin
      if (pwr) wp <= wp_inc;
      if (push && !stk_full) sp <= sp + 1'b1;
      else if (pop)          sp <= sp - 1'b1;
      if (tok_done && !last_tok) addr_inf_q <= addr_inf_q + 1'b1;
      if (state == S_FLUSH && stk_empty) begin
        top_addr_posf_q <= wp;
        en_inf_q        <= 1'b0;
      end
    end
  end

  always_ff @(posedge CLK_1MHz) begin
    if (push && !stk_full) stack[sp[IDXW-1:0]] <= bus.do_inf;
  end

  i2p_posf_ram #(
    .DWIDTH (DWIDTH),
    .AWIDTH (AWIDTH)
  ) u_posf_ram (
    .clk     (CLK_1MHz),
    .rst_n   (RSTN),
    .wr_vld  (pwr),
    .wr_addr (wp_inc),
    .wr_dat  (pwr_dat),
    .rd_addr (bus.addr_posf_b),
    .rd_dat  (bus.do_posf_b)
  );

endmodule

// File: tb/tb_mb_i2p_fix_arranger.sv
// Bench for mb_i2p_fix_arranger: directed expressions plus random token streams
// checked against a queue-based shunting-yard reference model.
module tb_mb_i2p_fix_arranger;

  localparam logic [11:0] LP = 12'h150;
  localparam logic [11:0] RP = 12'h151;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mb_i2p_fix_arranger_if bus ();

  mb_i2p_fix_arranger dut (
    .CLK_1MHz (clk),
    .RSTN     (rst_n),
    .bus      (bus)
  );

  logic [35:0] inf_mem [512];
  always @(posedge clk) begin
    if (bus.en_inf) bus.do_inf <= inf_mem[bus.addr_inf];
  end

  int          n_cmp = 0;
  int          n_err = 0;
  logic [35:0] tok_q[$];
  logic [35:0] exp_q[$];
  logic [35:0] got_q[$];
  int          cyc;

  function automatic logic [35:0] opnd(input logic [31:0] v);
    return {4'b0000, v};
  endfunction

  function automatic logic [35:0] opr(input logic [11:0] code);
    return {3'b000, 1'b1, 20'h0, code};
  endfunction

  task automatic load_tokens();
    @(negedge clk);
    foreach (tok_q[i]) inf_mem[i + 1] = tok_q[i];
    bus.top_addr_inf = 9'(tok_q.size());
  endtask

  task automatic convert(input int hold, output int c);
    @(negedge clk);
    bus.start = 1'b1;
    repeat (hold) @(negedge clk);
    bus.start = 1'b0;
    c = -1;
    for (int i = 0; i < 4000; i++) begin
      if (bus.finish === 1'b1) begin
        c = i;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic fetch(input int n);
    got_q.delete();
    for (int i = 1; i <= n; i++) begin
      @(negedge clk);
      bus.addr_posf_b = 9'(i);
      @(negedge clk);
      got_q.push_back(bus.do_posf_b);
    end
  endtask

  // Textbook shunting-yard over tok_q, stack capped at 16 entries.
  task automatic build_expected();
    logic [35:0] st[$];
    logic [35:0] t, tp;
    bit          go;
    exp_q.delete();
    foreach (tok_q[i]) begin
      t = tok_q[i];
      if (!t[32]) begin
        exp_q.push_back(t);
      end else if (t[11:0] == LP) begin
        if (st.size() < 16) st.push_back(t);
      end else if (t[11:0] == RP) begin
        go = 1'b1;
        while (go && st.size() > 0) begin
          tp = st.pop_back();
          if (tp[11:0] == LP) go = 1'b0;
          else exp_q.push_back(tp);
        end
      end else begin
        go = 1'b1;
        while (go && st.size() > 0) begin
          tp = st[$];
          if (tp[11:0] != LP && tp[7:4] >= t[7:4]) exp_q.push_back(st.pop_back());
          else go = 1'b0;
        end
        if (st.size() < 16) st.push_back(t);
      end
    end
    while (st.size() > 0) begin
      tp = st.pop_back();
      if (tp[11:0] != LP) exp_q.push_back(tp);
    end
  endtask

  task automatic set_example();
    tok_q = '{opnd(32'h42613333), opr(12'h171), opr(LP), opnd(32'h41500000), opr(12'h170),
              opnd(32'h4B000000), opr(RP), opr(12'h190), opnd(32'h4B400000)};
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.start = 1'b0;
    bus.top_addr_inf = '0;
    bus.addr_posf_b = '0;
    repeat (3) @(negedge clk);
    n_cmp++; if (bus.en_inf !== 1'b0) begin n_err++; $display("FAIL reset_en_inf: got %b want 0", bus.en_inf); end
    n_cmp++; if (bus.addr_inf !== 9'd0) begin n_err++; $display("FAIL reset_addr_inf: got %0d want 0", bus.addr_inf); end
    n_cmp++; if (bus.do_posf_b !== 36'd0) begin n_err++; $display("FAIL reset_do_posf_b: got %h want 0", bus.do_posf_b); end
    n_cmp++; if (bus.top_addr_posf !== 9'd0) begin n_err++; $display("FAIL reset_top_addr_posf: got %0d want 0", bus.top_addr_posf); end
    n_cmp++; if (bus.finish !== 1'b0) begin n_err++; $display("FAIL reset_finish: got %b want 0", bus.finish); end
    rst_n = 1'b1;
  endtask

  task automatic test_empty(input string tag);
    tok_q.delete();
    load_tokens();
    convert(1, cyc);
    n_cmp++; if (cyc < 0 || cyc > 2) begin n_err++; $display("FAIL %s_finish_latency: got %0d cycles want <=2", tag, cyc); end
    n_cmp++; if (bus.top_addr_posf !== 9'd0) begin n_err++; $display("FAIL %s_top: got %0d want 0", tag, bus.top_addr_posf); end
    n_cmp++; if (bus.en_inf !== 1'b0) begin n_err++; $display("FAIL %s_en_inf: got %b want 0", tag, bus.en_inf); end
  endtask

  task automatic test_example();
    set_example();
    exp_q = '{opnd(32'h42613333), opnd(32'h41500000), opnd(32'h4B000000), opr(12'h170),
              opnd(32'h4B400000), opr(12'h190), opr(12'h171)};
    load_tokens();
    convert(2, cyc);
    n_cmp++; if (cyc < 0) begin n_err++; $display("FAIL example_finish: timed out want finish=1"); end
    n_cmp++; if (bus.top_addr_posf !== 9'd7) begin n_err++; $display("FAIL example_top: got %0d want 7", bus.top_addr_posf); end
    fetch(7);
    foreach (exp_q[i]) begin
      n_cmp++; if (got_q[i] !== exp_q[i]) begin n_err++; $display("FAIL example_posf[%0d]: got %h want %h", i + 1, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_directed(input string tag, input int want_top);
    load_tokens();
    convert(1, cyc);
    n_cmp++; if (cyc < 0) begin n_err++; $display("FAIL %s_finish: timed out want finish=1", tag); end
    n_cmp++; if (bus.top_addr_posf !== 9'(want_top)) begin n_err++; $display("FAIL %s_top: got %0d want %0d", tag, bus.top_addr_posf, want_top); end
    fetch(exp_q.size());
    foreach (exp_q[i]) begin
      n_cmp++; if (got_q[i] !== exp_q[i]) begin n_err++; $display("FAIL %s_posf[%0d]: got %h want %h", tag, i + 1, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_assoc();
    tok_q = '{opnd(32'hA), opr(12'h171), opnd(32'hB), opr(12'h170), opnd(32'hC)};
    exp_q = '{opnd(32'hA), opnd(32'hB), opr(12'h171), opnd(32'hC), opr(12'h170)};
    test_directed("assoc", 5);
  endtask

  task automatic test_precedence();
    tok_q = '{opnd(32'hA), opr(12'h170), opnd(32'hB), opr(12'h190), opnd(32'hC)};
    exp_q = '{opnd(32'hA), opnd(32'hB), opnd(32'hC), opr(12'h190), opr(12'h170)};
    test_directed("prec", 5);
  endtask

  task automatic test_unbalanced();
    tok_q = '{opr(LP), opnd(32'hA), opr(12'h170), opnd(32'hB)};
    exp_q = '{opnd(32'hA), opnd(32'hB), opr(12'h170)};
    test_directed("unbal", 3);
    tok_q = '{opnd(32'hA), opr(RP), opr(12'h180), opnd(32'hB)};
    exp_q = '{opnd(32'hA), opnd(32'hB), opr(12'h180)};
    test_directed("stray_rp", 3);
  endtask

  task automatic test_stack_full();
    tok_q.delete();
    repeat (17) tok_q.push_back(opr(LP));
    tok_q.push_back(opnd(32'h11111111));
    tok_q.push_back(opr(12'h170));
    tok_q.push_back(opnd(32'h22222222));
    exp_q = '{opnd(32'h11111111), opnd(32'h22222222)};
    test_directed("stack_full", 2);
  endtask

  task automatic test_reset_mid_run();
    tok_q.delete();
    for (int i = 0; i < 30; i++) tok_q.push_back((i % 2 == 0) ? opnd(32'(i)) : opr(12'h160));
    load_tokens();
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (7) @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_cmp++; if (bus.en_inf !== 1'b0) begin n_err++; $display("FAIL midrst_en_inf: got %b want 0", bus.en_inf); end
    n_cmp++; if (bus.finish !== 1'b0) begin n_err++; $display("FAIL midrst_finish: got %b want 0", bus.finish); end
    n_cmp++; if (bus.top_addr_posf !== 9'd0) begin n_err++; $display("FAIL midrst_top: got %0d want 0", bus.top_addr_posf); end
    n_cmp++; if (bus.addr_inf !== 9'd0) begin n_err++; $display("FAIL midrst_addr_inf: got %0d want 0", bus.addr_inf); end
    @(negedge clk);
    rst_n = 1'b1;
    set_example();
    build_expected();
    test_directed("after_rst", 7);
  endtask

  task automatic test_random(input int iters);
    int          len, r;
    logic [11:0] code;
    for (int it = 0; it < iters; it++) begin
      tok_q.delete();
      len = $urandom_range(1, 40);
      for (int k = 0; k < len; k++) begin
        r = $urandom_range(0, 9);
        if (r < 4) begin
          tok_q.push_back(opnd($urandom));
        end else if (r == 4) begin
          tok_q.push_back(opr(LP));
        end else if (r == 5) begin
          tok_q.push_back(opr(RP));
        end else begin
          code = {4'h1, 4'($urandom_range(6, 9)), 4'($urandom_range(0, 15))};
          tok_q.push_back(opr(code));
        end
      end
      build_expected();
      test_directed($sformatf("rand%0d", it), exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_empty("empty_idle");
    test_example();
    test_empty("empty_after_run");
    test_assoc();
    test_precedence();
    test_unbalanced();
    test_stack_full();
    test_example();
    test_reset_mid_run();
    test_random(25);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
